seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the combinational datapath ALU for the MIPS multicycle core.
- Adds arithmetic flags, variable shifts, set-less-than, iterative multiply/divide into internal HI/LO registers, and a start/busy/done handshake.
- Sits in the EX stage; the control FSM waits on done before write-back.

---
 rtl/seq_alu_pkg.sv | 45 ++++
 rtl/seq_alu_muldiv.sv | 97 +++++++++
 rtl/seq_alu.sv | 156 +++++++++++++++
 tb/tb_seq_alu.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state encoding and decode helpers for seq_alu.
// Build option SEQ_ALU_DIV_EN adds DIV/DIVU to the multi-cycle op set.
package seq_alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SRL   = 5'd7;
    localparam logic [4:0] OP_SRA   = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;
    localparam logic [4:0] OP_PASSB = 5'd17;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic is_div(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Ops that occupy the iterative engine when the build supports them.
    function automatic logic is_muldiv(input logic [4:0] op);
`ifdef SEQ_ALU_DIV_EN
        return (op == OP_MULT) || (op == OP_MULTU) || is_div(op);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative radix-2 shift-add multiplier / restoring divider (divider only with SEQ_ALU_DIV_EN).
// Latency: fin pulses WIDTH cycles after start; results hold until the next start. No backpressure.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fin,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   hi_r, lo_r, opd_r;
    logic [CW-1:0]      cnt;
    logic               run, neg_q, sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     madd;
    logic [2*WIDTH-1:0] prod;

    // Iterate on magnitudes; the sign is re-applied on the way out.
    assign sgn   = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    assign madd  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : '0);
    assign prod  = neg_q ? -{hi_r, lo_r} : {hi_r, lo_r};

`ifdef SEQ_ALU_DIV_EN
    logic           div_r, neg_r;
    logic [WIDTH:0] rs, diff;

    assign rs     = {hi_r, lo_r[WIDTH-1]};
    assign diff   = rs - {1'b0, opd_r};
    assign res_lo = div_r ? (neg_q ? -lo_r : lo_r) : prod[WIDTH-1:0];
    assign res_hi = div_r ? (neg_r ? -hi_r : hi_r) : prod[2*WIDTH-1:WIDTH];
`else
    assign res_lo = prod[WIDTH-1:0];
    assign res_hi = prod[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r  <= '0;
            lo_r  <= '0;
            opd_r <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            fin   <= 1'b0;
            neg_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_r <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            fin <= 1'b0;
            if (start) begin
                run   <= 1'b1;
                cnt   <= '0;
                hi_r  <= '0;
                lo_r  <= a_mag;
                opd_r <= b_mag;
                neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef SEQ_ALU_DIV_EN
                div_r <= is_div(op);
                neg_r <= sgn & a[WIDTH-1];
`endif
            end else if (run) begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    run <= 1'b0;
                    fin <= 1'b1;
                end
`ifdef SEQ_ALU_DIV_EN
                // lo_r shifts the dividend out and the quotient in; hi_r is the partial remainder.
                if (div_r) begin
                    if (!diff[WIDTH]) begin
                        hi_r <= diff[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_r <= rs[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                {hi_r, lo_r} <= {madd, lo_r[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU with flags, HI/LO mul/div; DIV/DIVU only with SEQ_ALU_DIV_EN.
// Latency: 2 cycles for ALU ops and divide-by-zero, WIDTH+2 for mul/div. start is dropped while busy or in the done cycle.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       select,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);
    state_t           st;
    logic [WIDTH-1:0] a_q, b_q, bb, alu_y;
    logic [4:0]       sel_q;
    logic             cin_q, alu_c, alu_v;
    logic [WIDTH:0]   sum;
    logic             use_eng, eng_start, eng_fin;
    logic [WIDTH-1:0] eng_hi, eng_lo;

    // Divide-by-zero never enters the engine; it resolves in EXEC.
    assign use_eng   = is_muldiv(select) && !(is_div(select) && (b == '0));
    assign eng_start = (st == ST_IDLE) && start && use_eng;

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (eng_start),
        .op     (select),
        .a      (a),
        .b      (b),
        .fin    (eng_fin),
        .res_hi (eng_hi),
        .res_lo (eng_lo)
    );

    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        bb    = (sel_q == OP_SUB) ? ~b_q : b_q;
        sum   = {1'b0, a_q} + {1'b0, bb} + {{WIDTH{1'b0}}, cin_q};
        case (sel_q)
            OP_ADD, OP_SUB: begin
                alu_y = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a_q[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:   alu_y = a_q & b_q;
            OP_OR:    alu_y = a_q | b_q;
            OP_XOR:   alu_y = a_q ^ b_q;
            OP_NOR:   alu_y = ~(a_q | b_q);
            OP_SLL:   alu_y = a_q << b_q[SHW-1:0];
            OP_SRL:   alu_y = a_q >> b_q[SHW-1:0];
            OP_SRA:   alu_y = $signed(a_q) >>> b_q[SHW-1:0];
            OP_SLT:   alu_y = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_SLTU:  alu_y = {{(WIDTH-1){1'b0}}, a_q < b_q};
            OP_MFHI:  alu_y = hi;
            OP_MFLO:  alu_y = lo;
            OP_PASSB: alu_y = b_q;
            default:  alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            cin_q    <= 1'b0;
            y        <= '0;
            hi       <= '0;
            lo       <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: if (start) begin
                    a_q   <= a;
                    b_q   <= b;
                    sel_q <= select;
                    cin_q <= c_in;
                    busy  <= 1'b1;
                    if (!use_eng) st <= ST_EXEC;
`ifdef SEQ_ALU_DIV_EN
                    else if (is_div(select)) st <= ST_DIV;
`endif
                    else st <= ST_MUL;
                end
                ST_EXEC: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    st   <= ST_DONE;
`ifdef SEQ_ALU_DIV_EN
                    if (is_div(sel_q)) begin
                        y        <= '1;
                        lo       <= '1;
                        hi       <= a_q;
                        div_zero <= 1'b1;
                        zero     <= 1'b0;
                        negative <= 1'b1;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                    end else
`endif
                    begin
                        y        <= alu_y;
                        zero     <= (alu_y == '0);
                        negative <= alu_y[WIDTH-1];
                        carry    <= alu_c;
                        overflow <= alu_v;
                    end
                end
                ST_MUL, ST_DIV: if (eng_fin) begin
                    hi       <= eng_hi;
                    lo       <= eng_lo;
                    y        <= eng_lo;
                    zero     <= (eng_lo == '0);
                    negative <= eng_lo[WIDTH-1];
                    carry    <= 1'b0;
                    overflow <= 1'b0;
                    if (st == ST_DIV) div_zero <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    st       <= ST_DONE;
                end
                ST_DONE: begin
                    done <= 1'b0;
                    st   <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded bench for seq_alu: a reference model queues expected results at issue, a monitor checks each done pulse.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, c_in;
    logic [4:0]  select;
    logic [31:0] a, b, y, hi, lo;
    logic        zero, negative, carry, overflow, div_zero, busy, done;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .select(select), .c_in(c_in),
        .a(a), .b(b), .y(y), .hi(hi), .lo(lo), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .div_zero(div_zero), .busy(busy), .done(done)
    );

    typedef struct {
        int          lat;
        int          due;
        logic [31:0] y, hi, lo;
        logic [4:0]  fl;   // {zero, negative, carry, overflow, div_zero}
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0, n_fail = 0, n_done = 0, cyc = 0, lat_act;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] oa, input logic [31:0] ob, input logic ci);
        exp_t        e;
        logic [32:0] s;
        logic [63:0] p, uq, ur;
        longint      sxa, sxb, r, q, rm;
        logic        c, v, dz;
        sxa = longint'($signed(oa));
        sxb = longint'($signed(ob));
        e.lat = 2; e.due = 0; e.y = '0; e.hi = m_hi; e.lo = m_lo;
        c = 1'b0; v = 1'b0; dz = m_dz;
        case (op)
            OP_ADD: begin
                s = {1'b0, oa} + {1'b0, ob} + {32'b0, ci};
                e.y = s[31:0]; c = s[32];
                r = sxa + sxb + longint'(ci);
                v = (r != longint'($signed(e.y)));
            end
            OP_SUB: begin
                s = {1'b0, oa} + {1'b0, ~ob} + {32'b0, ci};
                e.y = s[31:0]; c = s[32];
                r = sxa - sxb - 1 + longint'(ci);
                v = (r != longint'($signed(e.y)));
            end
            OP_AND:   e.y = oa & ob;
            OP_OR:    e.y = oa | ob;
            OP_XOR:   e.y = oa ^ ob;
            OP_NOR:   e.y = ~(oa | ob);
            OP_SLL:   e.y = oa << ob[4:0];
            OP_SRL:   e.y = oa >> ob[4:0];
            OP_SRA:   e.y = $signed(oa) >>> ob[4:0];
            OP_SLT:   e.y = (sxa < sxb) ? 32'd1 : 32'd0;
            OP_SLTU:  e.y = (oa < ob) ? 32'd1 : 32'd0;
            OP_MFHI:  e.y = m_hi;
            OP_MFLO:  e.y = m_lo;
            OP_PASSB: e.y = ob;
            OP_MULT, OP_MULTU: begin
                if (op == OP_MULT) p = sxa * sxb;
                else               p = {32'b0, oa} * {32'b0, ob};
                e.hi = p[63:32]; e.lo = p[31:0]; e.y = e.lo; e.lat = 34;
            end
`ifdef SEQ_ALU_DIV_EN
            OP_DIV, OP_DIVU: begin
                if (ob == '0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = oa; dz = 1'b1;
                end else begin
                    if (op == OP_DIV) begin
                        q = sxa / sxb; rm = sxa % sxb;
                        uq = q; ur = rm;
                    end else begin
                        uq = {32'b0, oa} / {32'b0, ob};
                        ur = {32'b0, oa} % {32'b0, ob};
                    end
                    e.lo = uq[31:0]; e.hi = ur[31:0]; dz = 1'b0; e.lat = 34;
                end
                e.y = e.lo;
            end
`endif
            default: e.y = '0;
        endcase
        e.fl = {e.y == 32'd0, e.y[31], c, v, dz};
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
            end else begin
                mon_e = sb.pop_front();
                lat_act = cyc - mon_e.due + mon_e.lat;
                if (cyc !== mon_e.due) begin
                    n_fail++;
                    $display("FAIL latency: got %0d cycles, required %0d", lat_act, mon_e.lat);
                end
                n_checks++;
                if (y !== mon_e.y) begin
                    n_fail++;
                    $display("FAIL y: got %h, required %h", y, mon_e.y);
                end
                n_checks++;
                if (hi !== mon_e.hi) begin
                    n_fail++;
                    $display("FAIL hi: got %h, required %h", hi, mon_e.hi);
                end
                n_checks++;
                if (lo !== mon_e.lo) begin
                    n_fail++;
                    $display("FAIL lo: got %h, required %h", lo, mon_e.lo);
                end
                n_checks++;
                if ({zero, negative, carry, overflow, div_zero} !== mon_e.fl) begin
                    n_fail++;
                    $display("FAIL flags(z,n,c,v,dz): got %b, required %b",
                             {zero, negative, carry, overflow, div_zero}, mon_e.fl);
                end
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_at_done: got %b, required 0", busy);
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] oa, input logic [31:0] ob, input logic ci);
        exp_t e;
        e = model(op, oa, ob, ci);
        m_hi = e.hi; m_lo = e.lo; m_dz = e.fl[0];
        @(posedge clk); #1;
        start = 1'b1; select = op; a = oa; b = ob; c_in = ci;
        @(posedge clk); #1;
        start = 1'b0;
        e.due = cyc + e.lat - 1;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; select = '0; c_in = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({y, hi, lo} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: y/hi/lo %h %h %h, required 0", y, hi, lo);
        end
        n_checks++;
        if ({zero, negative, carry, overflow, div_zero, busy, done} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: flags/busy/done %b, required 0",
                     {zero, negative, carry, overflow, div_zero, busy, done});
        end
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_alu();
        logic [4:0] ops [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL,
                                  OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_PASSB, 5'd20};
        logic [31:0] ra, rb;
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        drain("add_ovf");
        n_checks++;
        if ({y, overflow, negative, carry} !== {32'h8000_0000, 3'b110}) begin
            n_fail++;
            $display("FAIL add_ovf: y=%h v,n,c=%b, required 80000000 110", y, {overflow, negative, carry});
        end
        issue(OP_SUB, 32'd5, 32'd5, 1'b1);
        drain("sub_eq");
        n_checks++;
        if ({y, zero, carry} !== {32'd0, 2'b11}) begin
            n_fail++;
            $display("FAIL sub_eq: y=%h z,c=%b, required 0 11", y, {zero, carry});
        end
        issue(OP_SRA, 32'h8000_0000, 32'd31, 1'b0);
        drain("sra");
        n_checks++;
        if (y !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sra: y=%h, required ffffffff", y);
        end
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            if (i % 7 == 0) ra = 32'h8000_0000;
            issue(ops[$urandom_range(12, 0)], ra, rb, 1'($urandom_range(1, 0)));
            drain("alu_rand");
        end
    endtask

    task automatic test_mul();
        issue(OP_MULT, -32'sd3, 32'd7, 1'b0);
        drain("mult_neg");
        n_checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_neg: hi:lo=%h%h, required ffffffffffffffeb", hi, lo);
        end
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0);
        drain("mflo");
        n_checks++;
        if (y !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mflo: y=%h, required ffffffeb", y);
        end
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        drain("mult_min");
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drain("multu_max");
        for (int i = 0; i < 6; i++) begin
            issue((i % 2 == 0) ? OP_MULT : OP_MULTU, $urandom, $urandom, 1'b0);
            drain("mul_rand");
            issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
            drain("mfhi");
        end
    endtask

    task automatic test_div();
`ifdef SEQ_ALU_DIV_EN
        issue(OP_DIV, -32'sd7, 32'd2, 1'b0);
        drain("div_neg");
        n_checks++;
        if ({lo, hi} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL div_neg: lo=%h hi=%h, required fffffffd ffffffff", lo, hi);
        end
        issue(OP_DIVU, 32'h0000_1234, 32'd0, 1'b0);
        drain("divu_zero");
        n_checks++;
        if ({div_zero, lo, hi} !== {1'b1, 32'hFFFF_FFFF, 32'h0000_1234}) begin
            n_fail++;
            $display("FAIL divu_zero: dz=%b lo=%h hi=%h, required 1 ffffffff 00001234", div_zero, lo, hi);
        end
        issue(OP_ADD, 32'd1, 32'd2, 1'b0);
        drain("dz_hold");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        drain("div_min");
        for (int i = 0; i < 6; i++) begin
            issue((i % 2 == 0) ? OP_DIV : OP_DIVU, $urandom, $urandom >> (i * 5), 1'b0);
            drain("div_rand");
        end
`else
        issue(OP_MULT, -32'sd3, 32'd7, 1'b0);
        drain("pre_div");
        issue(OP_DIV, 32'd9, 32'd3, 1'b0);
        drain("div_off");
        n_checks++;
        if ({y, hi, lo, div_zero} !== {32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}) begin
            n_fail++;
            $display("FAIL div_off: y=%h hi=%h lo=%h dz=%b, required 0 ffffffff ffffffeb 0", y, hi, lo, div_zero);
        end
        issue(OP_DIVU, 32'd9, 32'd0, 1'b0);
        drain("divu_off");
`endif
    endtask

    task automatic test_busy_ignore();
        int d0;
        d0 = n_done;
        issue(OP_MULTU, 32'h0001_2345, 32'h0000_6789, 1'b0);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; select = OP_ADD; a = 32'd1; b = 32'd1;
        @(posedge clk); #1 start = 1'b0;
        drain("busy_ignore");
        issue(OP_ADD, 32'd40, 32'd2, 1'b0);
        for (int i = 0; i < 10 && done !== 1'b1; i++) @(negedge clk);
        start = 1'b1; select = OP_PASSB; b = 32'hDEAD_BEEF;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (n_done - d0 !== 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start: %0d done pulses busy=%b, required 2 and 0", n_done - d0, busy);
        end
        sb.delete();
    endtask

    task automatic test_reset_midop();
        int d0;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        d0 = n_done;
        @(negedge clk);
        n_checks++;
        if ({busy, done, hi, lo, y} !== 98'd0) begin
            n_fail++;
            $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h y=%h, required all 0", busy, done, hi, lo, y);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (n_done !== d0) begin
            n_fail++;
            $display("FAIL abandoned_done: %0d done pulses after reset, required 0", n_done - d0);
        end
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_div();
        test_busy_ignore();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
